// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
//
// Shared definitions for the nibble-serial adder:
//   - NIB_W      : width of the arithmetic slice (one nibble)
//   - state_t    : controller states (IDLE / RUN / DONE)
//   - idx_width(): width of the nibble index counter for a given nibble count
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

  // Width of the single ripple-carry slice the wide add is streamed through.
  localparam int NIB_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width. A single-nibble adder still needs one bit so the
  // counter declaration stays legal.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_nibble_add.sv
// -----------------------------------------------------------------------------
// nibble_add
//
// Combinational NIB_W-bit ripple-carry adder: {o_cout, o_sum} = i_a + i_b + i_cin.
// This is the one arithmetic slice the serial adder reuses for every nibble.
//
// Ports:
//   i_a    in  NIB_W  addend nibble
//   i_b    in  NIB_W  addend nibble
//   i_cin  in  1      carry in
//   o_sum  out NIB_W  sum nibble
//   o_cout out 1      carry out of the top bit
// -----------------------------------------------------------------------------
module nibble_add
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_sum,
  output logic             o_cout
);

  // Explicit bit-level ripple so the slice maps onto plain full adders.
  always_comb begin
    logic [NIB_W:0] v_c;
    v_c    = '0;
    o_sum  = '0;
    v_c[0] = i_cin;
    for (int i = 0; i < NIB_W; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ v_c[i];
      v_c[i+1]  = (i_a[i] & i_b[i]) | (v_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = v_c[NIB_W];
  end

endmodule : nibble_add

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder. Operands are accepted over a valid/ready
// handshake, then added one nibble per clock (least-significant first) through
// a single nibble_add slice, with the slice carry fed back between steps. The
// result is presented over a valid/ready handshake and held until taken.
//
// Latency: out_valid rises NIB = WIDTH/4 cycles after the accept edge;
// minimum initiation interval is NIB+2 cycles.
//
// Optional feature (compile-time macro NIBBLE_SERIAL_ADDER_SUB_EN):
//   adds input port 'sub'. With sub=1 at accept, the block computes a-b
//   (b inverted, carry forced to 1, c_in ignored); c_out=1 means no borrow.
//
// Parameters:
//   WIDTH      operand/result width, a multiple of 4 and at least 4
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands present
//   in_ready   out  1      block can accept operands (IDLE only)
//   a          in   WIDTH  addend
//   b          in   WIDTH  addend
//   c_in       in   1      carry into nibble 0
//   sub        in   1      subtract select (only with NIBBLE_SERIAL_ADDER_SUB_EN)
//   out_valid  out  1      sum/c_out valid (DONE only)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  registered result
//   c_out      out  1      carry out of the top nibble
//   busy       out  1      operation in flight or result pending
//
// All outputs come from registers or from the state register alone, so there
// is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;

  // ---------------------------------------------------------------------------
  // Combinational wires
  // ---------------------------------------------------------------------------
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic [NIB_W-1:0] w_nib_a;
  logic [NIB_W-1:0] w_nib_b;
  logic [NIB_W-1:0] w_nib_sum;
  logic             w_nib_cout;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_idx == IDX_LAST);

  // Operand conditioning at accept. Subtraction is a + ~b + 1, so the slice
  // itself never needs to know which operation is running.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign w_b_in   = sub ? ~b : b;
  assign w_cin_in = sub ? 1'b1 : c_in;
`else
  assign w_b_in   = b;
  assign w_cin_in = c_in;
`endif

  // Current nibble of each latched operand, selected by the step index.
  assign w_nib_a = r_a[int'(r_idx) * NIB_W +: NIB_W];
  assign w_nib_b = r_b[int'(r_idx) * NIB_W +: NIB_W];

  // ---------------------------------------------------------------------------
  // The single shared arithmetic slice
  // ---------------------------------------------------------------------------
  nibble_add u_nibble_add (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (in_valid)  w_state_nxt = RUN;
      RUN:  if (w_last)    w_state_nxt = DONE;
      // No accept in the handshake cycle: DONE always returns through IDLE.
      DONE: if (out_ready) w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from state only
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      IDLE: in_ready  = 1'b1;
      RUN:  busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

  // ---------------------------------------------------------------------------
  // Datapath: operand latch, nibble index, carry chain and result assembly.
  // Reset clears everything so an aborted operation leaves no trace.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx) * NIB_W +: NIB_W] <= w_nib_sum;
          r_carry                             <= w_nib_cout;
          if (w_last) begin
            r_cout <= w_nib_cout;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;  // DONE: result frozen until taken
      endcase
    end
  end

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Scoreboard bench for nibble_serial_adder (WIDTH=16). The driver issues
// operations and pushes the reference result computed with plain integer
// arithmetic; an independent monitor watches the output handshake, checks
// latency, hold stability, ready recovery and reset state, and pops/compares
// results. Honours NIBBLE_SERIAL_ADDER_SUB_EN when defined.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   bp_mode = 0;  // 0: always ready, 1: random, 2: hold low 5 cycles

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the sum or difference as whole numbers.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    exp_t        e;
    longint      r;
    logic [63:0] rv;
    if (SUB_EN && s) begin
      e.s = x - y;
      e.c = (x >= y);
    end else begin
      r   = longint'(x) + longint'(y) + longint'(ci);
      rv  = r;
      e.s = rv[W-1:0];
      e.c = rv[W];
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    int           ncyc;
    bit           post_rst;
    bit           prev_ov;
    bit           prev_hs;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    exp_t         e;
    int           t_acc;
    ncyc = 0; post_rst = 1'b0; prev_ov = 1'b0; prev_hs = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        acc_q.delete();
        post_rst = 1'b1;
        prev_ov  = 1'b0;
        prev_hs  = 1'b0;
        continue;
      end
      if (post_rst) begin
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_c_out",     64'(c_out),     64'd0);
        post_rst = 1'b0;
      end
      if (prev_hs) begin
        chk("ready_after_take", 64'(in_ready),  64'd1);
        chk("valid_after_take", 64'(out_valid), 64'd0);
      end
      if (in_valid && in_ready) acc_q.push_back(ncyc);
      if (out_valid && !prev_ov) begin
        chk("unexpected_result", 64'(exp_q.size() > 0), 64'd1);
        if (acc_q.size() == 0) begin
          chk("accept_seen", 64'd0, 64'd1);
        end else begin
          t_acc = acc_q.pop_front();
          chk("latency", 64'(ncyc - t_acc - 1), 64'(NIB));
        end
      end
      if (out_valid && prev_ov) begin
        chk("hold_sum",   64'(sum),   64'(prev_sum));
        chk("hold_c_out", 64'(c_out), 64'(prev_cout));
      end
      if (out_valid) chk("in_ready_in_done", 64'(in_ready), 64'd0);
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sum",   64'(sum),   64'(e.s));
        chk("c_out", 64'(c_out), 64'(e.c));
      end
      prev_ov   = out_valid;
      prev_hs   = out_valid && out_ready;
      prev_sum  = sum;
      prev_cout = c_out;
    end
  end

  // ---------------- result sink (out_ready) ----------------
  initial begin : sink
    int hold_cnt;
    hold_cnt  = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && hold_cnt < 5) begin
            out_ready = 1'b0;
            hold_cnt++;
          end else begin
            out_ready = 1'b1;
            if (!out_valid) hold_cnt = 0;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic ic, input logic is, input bit push,
                       input bit hold_valid);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    while (!in_ready) begin
      t++;
      if (t > 200) begin
        $display("FAIL issue_timeout: in_ready stayed 0, required 1");
        $fatal(1);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    a = ia; b = ib; c_in = ic; sub = is;
    if (push) exp_q.push_back(model(ia, ib, ic, is));
    @(posedge clk);
    #1;
    // Operands scrambled after accept; a second request may be held during RUN.
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    in_valid = hold_valid;
    if (hold_valid) begin
      repeat (2) begin
        @(posedge clk);
        #1;
        a = W'($urandom); b = W'($urandom);
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0) begin
      t++;
      if (t > 1000) begin
        $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        $fatal(1);
      end
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : driver
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    bp_mode = 2;
    issue(16'hA5C3, 16'h7E19, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    bp_mode = 0;

    issue(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Abort mid-RUN: no result may appear.
    issue(16'h8888, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (NIB + 4) @(posedge clk);
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    if (SUB_EN) begin
      issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b0);
      issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b0);
      drain();
    end

    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0));
    end
    drain();
    bp_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that streams WIDTH-bit operands through a single 4-bit ripple-carry slice, one nibble per clock, least-significant nibble first. Carry out of each nibble becomes carry in of the next, trading latency for area. Sits between an operand source with a valid/ready handshake and a result consumer, letting the datapath reuse the team's 4-bit full adder for wider words.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIB (derived, not overridable), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, c_in present.
- in_ready  output  1  block accepts operands; high only in IDLE.
- a  input  WIDTH  addend.
- b  input  WIDTH  addend.
- c_in  input  1  carry into nibble 0.
- out_valid  output  1  sum and c_out valid; high only in DONE.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  registered result.
- c_out  output  1  carry out of the top nibble.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch a, b, and carry register = c_in, clear idx to 0, clear sum, go to RUN.
- RUN: each cycle the slice adds a[4*idx+:4], b[4*idx+:4], and the carry register. Write the result into sum[4*idx+:4] and the slice carry into the carry register, then idx++. After the step with idx==NIB-1, go to DONE with c_out = final carry.
- DONE: out_valid=1; sum and c_out held stable. On out_ready, go to IDLE. No new accept in the same cycle.
- in_valid while not IDLE: ignored, no side effects. Operands are sampled only at the accept edge; later changes on a/b have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; {c_out,sum} = a+b+c_in exactly.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, idx=0, carry register=0.
- Reset asserted mid-RUN or mid-DONE: in-flight operation discarded, all registers return to reset values immediately. No result is emitted.

## Timing
- Accept edge E0. Nibble k is written at edge E(k+1). DONE is entered at edge E(NIB). out_valid is high in the cycle after E(NIB), i.e. NIB cycles after acceptance.
- Result handshake at edge H: in_ready is high from H+1. Minimum initiation interval is NIB+2 cycles.
- out_ready low: stay in DONE indefinitely, outputs frozen.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- NIBBLE_SERIAL_ADDER_SUB_EN defined: adds input port sub (1 bit), sampled at accept. When sub=1, latch ~b and force carry register=1 (c_in ignored), giving sum=a-b mod 2^WIDTH and c_out=1 meaning no borrow. When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; add only.

## Structure
- Package nibble_serial_adder_pkg: state enum (IDLE/RUN/DONE), NIB_W=4 constant.
- One sub-module, nibble_add: combinational 4-bit a+b+cin producing a 4-bit sum and a carry. It is instantiated once. The FSM, operand registers, index counter and carry register live in the top module.

## Test plan
- WIDTH=16: a=0x1234, b=0x4321, c_in=0 -> sum=0x5555, c_out=0, out_valid exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Also a=0xFFFF, b=0x0000, c_in=1 -> same result, confirming the carry chain across all four nibbles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum and c_out stable, in_ready=0. Raise out_ready -> in_ready=1 on the next cycle.
- Assert in_valid with new operands during RUN -> ignored; the result matches the first operands only.
- Pulse rst_n low 2 cycles into RUN -> out_valid never rises, sum=0, in_ready=1 after release. The next operation (0x0F0F+0x00F1) gives 0x1000.
- With NIBBLE_SERIAL_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0. a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
